bnn_layer_sequencer: RTL and testbench

Sequences a single shared XNOR-popcount neuron datapath across `NUM_NEURONS` logical neurons to evaluate one fully connected binary layer. Buffers `CHUNKS` activation bytes, streams one weight byte per cycle, accumulates popcounts per neuron, and thresholds each neuron to produce one output bit. It sits between the TinyTapeout top-level I/O (`ui_in`/`uio_in` byte streams) and the layer output register.

---
 rtl/bnn_pkg.sv | 19 +
 rtl/bnn_xnor_popcount.sv | 21 ++
 rtl/bnn_layer_sequencer.sv | 161 ++++++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and sizing helpers for the binary-layer sequencer.
// Optional feature macro: BNN_SEQ_INPUT_REUSE_EN.
package bnn_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_IN,
    S_COMPUTE,
    S_COMPARE,
    S_DONE
  } bnn_seq_state_t;

  function automatic int acc_w(input int chunks);
    return $clog2(BYTE_W * chunks + 1);
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount of one activation byte against one weight byte.
// Shared by every logical neuron of the layer.
module bnn_xnor_popcount
  import bnn_pkg::*;
(
  input  logic [BYTE_W-1:0] act,
  input  logic [BYTE_W-1:0] wgt,
  output logic [3:0]        pop
);

  logic [BYTE_W-1:0] match;

  always_comb begin
    match = ~(act ^ wgt);
    pop   = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      pop = pop + {3'b000, match[i]};
    end
  end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Time-multiplexes one XNOR-popcount datapath over NUM_NEURONS neurons.
// Define BNN_SEQ_INPUT_REUSE_EN to add reuse_in (skip LOAD_IN after a pass).
module bnn_layer_sequencer
  import bnn_pkg::*;
#(
  parameter  int NUM_NEURONS = 8,
  parameter  int CHUNKS      = 4,
  localparam int ACC_W       = acc_w(CHUNKS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
`ifdef BNN_SEQ_INPUT_REUSE_EN
  input  logic                   reuse_in,
`endif
  input  logic [ACC_W-1:0]       thr,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             w_data,
  input  logic                   w_valid,
  output logic                   w_ready,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_NEURONS-1:0] out_bits
);

  localparam int KW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURONS - 1);

  bnn_seq_state_t          state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [NW-1:0]           n_q, n_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [ACC_W-1:0]        thr_q, thr_d;
  logic [7:0]              buf_q [CHUNKS];
  logic [7:0]              buf_d [CHUNKS];
  logic [NUM_NEURONS-1:0]  shadow_q, shadow_d;
  logic [NUM_NEURONS-1:0]  out_q, out_d;
  logic [3:0]              pop;
  logic                    reuse_go;

`ifdef BNN_SEQ_INPUT_REUSE_EN
  logic pass_q, pass_d;
  assign reuse_go = reuse_in & pass_q;
`else
  assign reuse_go = 1'b0;
`endif

  bnn_xnor_popcount u_pop (
    .act (buf_q[k_q]),
    .wgt (w_data),
    .pop (pop)
  );

  assign in_ready = (state_q == S_LOAD_IN);
  assign w_ready  = (state_q == S_COMPUTE);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign out_bits = out_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    acc_d    = acc_q;
    thr_d    = thr_q;
    buf_d    = buf_q;
    shadow_d = shadow_q;
    out_d    = out_q;
`ifdef BNN_SEQ_INPUT_REUSE_EN
    pass_d   = pass_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          thr_d = thr;
          k_d   = '0;
          n_d   = '0;
          acc_d = '0;
          state_d = reuse_go ? S_COMPUTE : S_LOAD_IN;
        end
      end
      S_LOAD_IN: begin
        if (in_valid) begin
          buf_d[k_q] = in_data;
          if (k_q == K_LAST) begin
            k_d     = '0;
            n_d     = '0;
            acc_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (w_valid) begin
          acc_d = acc_q + ACC_W'(pop);
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_COMPARE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_COMPARE: begin
        shadow_d[n_q] = (acc_q >= thr_q);
        acc_d = '0;
        k_d   = '0;
        if (n_q == N_LAST) begin
          // publish together with the done pulse
          out_d   = shadow_d;
          state_d = S_DONE;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = S_COMPUTE;
        end
      end
      S_DONE: begin
`ifdef BNN_SEQ_INPUT_REUSE_EN
        pass_d  = 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      thr_q    <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      for (int i = 0; i < CHUNKS; i++) buf_q[i] <= '0;
`ifdef BNN_SEQ_INPUT_REUSE_EN
      pass_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      thr_q    <= thr_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      for (int i = 0; i < CHUNKS; i++) buf_q[i] <= buf_d[i];
`ifdef BNN_SEQ_INPUT_REUSE_EN
      pass_q   <= pass_d;
`endif
    end
  end

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed bench for bnn_layer_sequencer with NUM_NEURONS=2, CHUNKS=2.
// Cycle 0 is the cycle in which start is sampled high.
module tb_bnn_layer_sequencer;

  localparam int NN = 2;
  localparam int CH = 2;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          reuse_in;
  logic [AW-1:0] thr;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    w_data;
  logic          w_valid;
  logic          w_ready;
  logic          busy;
  logic          done;
  logic [NN-1:0] out_bits;

  int n_cmp;
  int n_fail;

  int r_done_cnt;
  int r_done_cyc;
  int r_bits;
  int r_busy_bad;
  int r_inrdy;

  bnn_layer_sequencer #(
    .NUM_NEURONS (NN),
    .CHUNKS      (CH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef BNN_SEQ_INPUT_REUSE_EN
    .reuse_in (reuse_in),
`endif
    .thr      (thr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .w_data   (w_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .busy     (busy),
    .done     (done),
    .out_bits (out_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one pass; starts and ends just after a negedge.
  task automatic run_pass(
    input logic [AW-1:0] thr_v,
    input logic [7:0]    a0,
    input logic [7:0]    a1,
    input logic [31:0]   w,
    input int            in_gap_at,
    input int            in_gap_len,
    input int            w_gap_at,
    input int            w_gap_len,
    input int            extra_start,
    input int            abort_cyc,
    input logic          reuse
  );
    int ii;
    int wi;
    int igap;
    int wgap;
    logic iv_s;
    logic ir_s;
    logic wv_s;
    logic wr_s;
    logic [7:0] acts [2];
    acts[0] = a0;
    acts[1] = a1;
    ii = 0;
    wi = 0;
    igap = in_gap_len;
    wgap = w_gap_len;
    r_done_cnt = 0;
    r_done_cyc = -1;
    r_bits = -1;
    r_busy_bad = 0;
    r_inrdy = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      start    = (cyc == 0) || (cyc == extra_start);
      thr      = (cyc == 0) ? thr_v : ~thr_v;
      reuse_in = reuse;
      in_data  = acts[ii < 2 ? ii : 1];
      w_data   = w[(wi < 4 ? wi : 3)*8 +: 8];
      in_valid = 1'b0;
      w_valid  = 1'b0;
      if (in_ready) begin
        r_inrdy++;
        if (ii == in_gap_at && igap > 0) igap--;
        else in_valid = 1'b1;
      end
      if (w_ready) begin
        if (wi == w_gap_at && wgap > 0) wgap--;
        else w_valid = 1'b1;
      end
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_out_bits", int'(out_bits), 0);
      end
      if (done) begin
        r_done_cnt++;
        r_done_cyc = cyc;
        r_bits = int'(out_bits);
      end
      if (cyc >= 1 && r_done_cnt == 0 && !busy) r_busy_bad++;
      iv_s = in_valid;
      ir_s = in_ready;
      wv_s = w_valid;
      wr_s = w_ready;
      @(posedge clk);
      if (iv_s && ir_s) ii++;
      if (wv_s && wr_s) wi++;
      @(negedge clk);
      rst_n = 1'b1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    w_valid  = 1'b0;
    reuse_in = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic [AW-1:0] thr;
    logic [7:0]   a0;
    logic [7:0]   a1;
    logic [31:0]  w;
    int           bits;
    int           cyc;
  } vec_t;

  vec_t vecs [5];

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    reuse_in = 1'b0;
    thr      = '0;
    in_data  = '0;
    in_valid = 1'b0;
    w_data   = '0;
    w_valid  = 1'b0;

    // weights packed {n1c1, n1c0, n0c1, n0c0}
    vecs[0] = '{"basic",  5'd8,  8'hFF, 8'hFF, 32'h0000FFFF, 1, 9};
    vecs[1] = '{"thr0",   5'd0,  8'hFF, 8'hFF, 32'h0000FFFF, 3, 9};
    vecs[2] = '{"thr16",  5'd16, 8'hFF, 8'hFF, 32'h0000FFFF, 1, 9};
    vecs[3] = '{"thr17",  5'd17, 8'hFF, 8'hFF, 32'h0000FFFF, 0, 9};
    vecs[4] = '{"mixed",  5'd8,  8'hA5, 8'h0F, 32'hF05AF0A5, 1, 9};

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_w_ready", int'(w_ready), 0);
    chk("rst_out_bits", int'(out_bits), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_pass(vecs[i].thr, vecs[i].a0, vecs[i].a1, vecs[i].w,
               -1, 0, -1, 0, -1, -1, 1'b0);
      chk({vecs[i].name, "_bits"}, r_bits, vecs[i].bits);
      chk({vecs[i].name, "_done_cyc"}, r_done_cyc, vecs[i].cyc);
      chk({vecs[i].name, "_done_cnt"}, r_done_cnt, 1);
      chk({vecs[i].name, "_busy"}, r_busy_bad, 0);
      chk({vecs[i].name, "_idle_after"}, int'(busy), 0);
      chk({vecs[i].name, "_hold"}, int'(out_bits), vecs[i].bits);
    end

    run_pass(5'd8, 8'hFF, 8'hFF, 32'h0000FFFF, -1, 0, 3, 3, -1, -1, 1'b0);
    chk("w_stall_bits", r_bits, 1);
    chk("w_stall_done_cyc", r_done_cyc, 12);

    run_pass(5'd8, 8'hFF, 8'hFF, 32'h0000FFFF, 1, 2, -1, 0, -1, -1, 1'b0);
    chk("in_stall_bits", r_bits, 1);
    chk("in_stall_done_cyc", r_done_cyc, 11);

    run_pass(5'd0, 8'hFF, 8'hFF, 32'h0000FFFF, -1, 0, -1, 0, 4, -1, 1'b0);
    chk("start_busy_cnt", r_done_cnt, 1);
    chk("start_busy_bits", r_bits, 3);
    chk("start_busy_cyc", r_done_cyc, 9);

    run_pass(5'd8, 8'hFF, 8'hFF, 32'h0000FFFF, -1, 0, -1, 0, -1, 6, 1'b0);
    chk("abort_done_cnt", r_done_cnt, 0);
    chk("abort_out_after", int'(out_bits), 0);

    run_pass(5'd8, 8'hFF, 8'hFF, 32'hFFFF0000, -1, 0, -1, 0, -1, -1, 1'b0);
    chk("post_abort_bits", r_bits, 2);
    chk("post_abort_cyc", r_done_cyc, 9);

`ifdef BNN_SEQ_INPUT_REUSE_EN
    run_pass(5'd8, 8'hFF, 8'hFF, 32'h0000FFFF, -1, 0, -1, 0, -1, -1, 1'b0);
    chk("pre_reuse_bits", r_bits, 1);
    run_pass(5'd8, 8'h00, 8'h00, 32'hFFFF0000, -1, 0, -1, 0, -1, -1, 1'b1);
    chk("reuse_inrdy", r_inrdy, 0);
    chk("reuse_done_cyc", r_done_cyc, 7);
    chk("reuse_bits", r_bits, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
